// File: rtl/henon_draw_pkg.sv
// Shared types and constants for the Henon-map card drawer.
package henon_draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT,
    EVAL,
    PROBE,
    PRESENT
  } draw_state_t;

  localparam logic [31:0] ONE_Q31 = 32'h7FFF_FFFF;
  // 1.4 lies outside the Q1.31 range, so A_DEF holds a/2 (0.7); the map applies the factor of two.
  localparam logic [31:0] A_DEF   = 32'h5999_999A;
  localparam logic [31:0] B_DEF   = 32'h2666_6666;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/henon_draw_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to dither the map perturbation.
module henon_draw_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst)
      value <= '0;
    else if (load)
      value <= seed;
    else if (step)
      value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  end

endmodule

// File: rtl/henon_card_drawer.sv
// Seeds and burns in the Henon map, then draws non-repeating tarot cards from x (orientation from y).
// Optional LFSR dither on map_perturb is enabled by defining HENON_DRAW_LFSR_PERTURB_EN.
//
// state   | meaning
// IDLE    | waiting for draw_req (only after a cfg_load)
// KICK    | map_start high for one cycle
// WAIT    | waiting for map_done; burn-in or evaluate
// EVAL    | map x to card index, reject duplicates
// PROBE   | linear search for a free card after too many rejects
// PRESENT | card held on the valid/ready output
module henon_card_drawer
  import henon_draw_pkg::*;
#(
  parameter int NUM_CARDS  = 78,
  parameter int BURN_IN    = 16,
  parameter int MAX_REJECT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_load,
  input  logic [31:0] seed_x,
  input  logic [31:0] seed_y,
  input  logic [31:0] coef_a,
  input  logic [31:0] coef_b,
  input  logic [31:0] perturb_seed,
  input  logic        draw_req,
  output logic        busy,
  output logic        deck_empty,
  output logic        card_valid,
  input  logic        card_ready,
  output logic [6:0]  card_idx,
  output logic        card_rev,
  output logic        map_start,
  output logic [31:0] map_x,
  output logic [31:0] map_y,
  output logic [31:0] map_a,
  output logic [31:0] map_b,
  output logic [31:0] map_perturb,
  input  logic [31:0] map_x_out,
  input  logic [31:0] map_y_out,
  input  logic        map_done
);

  localparam int CNT_W = clog2(NUM_CARDS + 1);

  draw_state_t      state;
  logic [31:0]      x_reg, y_reg;
  logic [127:0]     used;
  logic [15:0]      burn_cnt;
  logic [15:0]      rej_cnt;
  logic [CNT_W-1:0] drawn_cnt;
  logic [6:0]       probe;
  logic             configured;

  logic [6:0]       eval_idx;
  logic [6:0]       probe_nxt;
  logic [15:0]      rej_nxt;

  // Multiply-high: floor(x * N / 2^32) is always below N.
  assign eval_idx  = 7'(({7'd0, x_reg} * 39'(NUM_CARDS)) >> 32);
  assign probe_nxt = (probe == 7'(NUM_CARDS - 1)) ? 7'd0 : probe + 7'd1;
  assign rej_nxt   = rej_cnt + 16'd1;

  assign map_x = x_reg;
  assign map_y = y_reg;
  assign map_a = coef_a;
  assign map_b = coef_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      used       <= '0;
      burn_cnt   <= '0;
      rej_cnt    <= '0;
      drawn_cnt  <= '0;
      probe      <= '0;
      configured <= 1'b0;
      busy       <= 1'b0;
      deck_empty <= 1'b0;
      card_valid <= 1'b0;
      card_idx   <= '0;
      card_rev   <= 1'b0;
      map_start  <= 1'b0;
    end else begin
      map_start  <= 1'b0;
      deck_empty <= (drawn_cnt == CNT_W'(NUM_CARDS));
      if (cfg_load) begin
        x_reg      <= seed_x;
        y_reg      <= seed_y;
        used       <= '0;
        drawn_cnt  <= '0;
        card_valid <= 1'b0;
        burn_cnt   <= 16'(BURN_IN);
        configured <= 1'b1;
        state      <= KICK;
        map_start  <= 1'b1;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (draw_req && configured && !deck_empty) begin
              state     <= KICK;
              map_start <= 1'b1;
              busy      <= 1'b1;
            end
          end
          KICK: state <= WAIT;
          WAIT: begin
            if (map_done) begin
              x_reg <= map_x_out;
              y_reg <= map_y_out;
              if (burn_cnt != 16'd0) begin
                burn_cnt <= burn_cnt - 16'd1;
                if (burn_cnt == 16'd1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state     <= KICK;
                  map_start <= 1'b1;
                end
              end else begin
                state <= EVAL;
              end
            end
          end
          EVAL: begin
            if (!used[eval_idx]) begin
              used[eval_idx] <= 1'b1;
              drawn_cnt      <= drawn_cnt + CNT_W'(1);
              card_idx       <= eval_idx;
              card_rev       <= y_reg[31];
              card_valid     <= 1'b1;
              busy           <= 1'b0;
              state          <= PRESENT;
            end else begin
              rej_cnt <= rej_nxt;
              if (rej_nxt > 16'(MAX_REJECT)) begin
                probe <= eval_idx;
                state <= PROBE;
              end else begin
                state     <= KICK;
                map_start <= 1'b1;
              end
            end
          end
          // Terminates within NUM_CARDS-1 steps: draws only start while a card is free.
          PROBE: begin
            if (!used[probe_nxt]) begin
              used[probe_nxt] <= 1'b1;
              drawn_cnt       <= drawn_cnt + CNT_W'(1);
              card_idx        <= probe_nxt;
              card_rev        <= y_reg[31];
              card_valid      <= 1'b1;
              busy            <= 1'b0;
              state           <= PRESENT;
            end else begin
              probe <= probe_nxt;
            end
          end
          PRESENT: begin
            if (card_ready) begin
              card_valid <= 1'b0;
              rej_cnt    <= '0;
              state      <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef HENON_DRAW_LFSR_PERTURB_EN
  logic [15:0] lfsr;

  henon_draw_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (cfg_load),
    .seed  (perturb_seed[15:0] | 16'h0001),
    .step  (state == KICK),
    .value (lfsr)
  );

  assign map_perturb = {{8{lfsr[15]}}, lfsr, 8'h00};
`else
  logic [31:0] perturb_reg;

  always_ff @(posedge clk) begin
    if (rst)
      perturb_reg <= '0;
    else if (cfg_load)
      perturb_reg <= perturb_seed;
  end

  assign map_perturb = perturb_reg;
`endif

endmodule
